// File: rtl/arbitro_rom.sv
// rtl/arbitro_rom.sv - two-requester round-robin arbiter and boot ROM read sequencer
module arbitro_rom #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        req0,
  input  logic [23:0] a0,
  output logic        ack0,
  input  logic        req1,
  input  logic [23:0] a1,
  output logic        ack1,
  output logic [7:0]  dato,
  output logic [23:0] a23_a0,
  output logic        s_,
  output logic        mr_,
  input  logic [7:0]  d7_d0
);

  typedef enum logic [1:0] {IDLE, ADDR, READ, ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_n;
  logic        last, last_n;
  logic [3:0]  cnt, cnt_n;
  logic        s_n, mr_n, ack0_n, ack1_n;
  logic [7:0]  dato_n;
  logic [23:0] addr_n;
  logic        grant;
  logic        gnt_req;

  // On a tie the requester that was not served last wins; otherwise whoever asks.
  assign grant   = (req0 && req1) ? ~last : req1;
  assign gnt_req = last ? req1 : req0;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= 4'd0;
      s_     <= 1'b1;
      mr_    <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      dato   <= 8'h00;
      a23_a0 <= 24'h000000;
    end else begin
      state  <= state_n;
      last   <= last_n;
      cnt    <= cnt_n;
      s_     <= s_n;
      mr_    <= mr_n;
      ack0   <= ack0_n;
      ack1   <= ack1_n;
      dato   <= dato_n;
      a23_a0 <= addr_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    s_n     = s_;
    mr_n    = mr_;
    ack0_n  = ack0;
    ack1_n  = ack1;
    dato_n  = dato;
    addr_n  = a23_a0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          addr_n  = grant ? a1 : a0;
          s_n     = 1'b0;
          last_n  = grant;
          state_n = ADDR;
        end
      end
      ADDR: begin
        // Select was asserted one cycle earlier to give the ROM address setup.
        mr_n    = 1'b0;
        cnt_n   = WAIT_INIT;
        state_n = READ;
      end
      READ: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          dato_n  = d7_d0;
          mr_n    = 1'b1;
          s_n     = 1'b1;
          ack0_n  = ~last;
          ack1_n  = last;
          state_n = ACK;
        end
      end
      ACK: begin
        if (!gnt_req) begin
          ack0_n  = 1'b0;
          ack1_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arbitro_rom.sv
// tb/tb_arbitro_rom.sv - directed self-checking bench for arbitro_rom
module tb_arbitro_rom;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  logic        clock = 1'b0;
  logic        reset_;
  logic        req0, req1;
  logic [23:0] a0, a1;
  logic        ack0, ack1;
  logic [7:0]  dato;
  logic [23:0] a23_a0;
  logic        s_, mr_;
  wire  [7:0]  d7_d0;

  logic        req_w;
  logic [23:0] a_w;
  logic        ack_w, ack1_w;
  logic [7:0]  dato_w;
  logic [23:0] addr_w;
  logic        s_w, mr_w;
  wire  [7:0]  d_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] rom(input logic [23:0] a);
    case (a)
      24'hFF0000: rom = NOP_OPCODE;
      24'hFF0002: rom = 8'h41;
      24'hFF0007: rom = 8'h20;
      24'hFF0013: rom = 8'h5A;
      default:    rom = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign d7_d0 = (!s_ && !mr_)   ? rom(a23_a0) : 8'hzz;
  assign d_w   = (!s_w && !mr_w) ? rom(addr_w) : 8'hzz;

  arbitro_rom #(.WAIT_CYCLES(2)) u_dut (
    .clock(clock), .reset_(reset_),
    .req0(req0), .a0(a0), .ack0(ack0),
    .req1(req1), .a1(a1), .ack1(ack1),
    .dato(dato), .a23_a0(a23_a0), .s_(s_), .mr_(mr_), .d7_d0(d7_d0)
  );

  arbitro_rom #(.WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset_(reset_),
    .req0(req_w), .a0(a_w), .ack0(ack_w),
    .req1(1'b0), .a1(24'h000000), .ack1(ack1_w),
    .dato(dato_w), .a23_a0(addr_w), .s_(s_w), .mr_(mr_w), .d7_d0(d_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(output int who, output int cycles);
    who    = -1;
    cycles = 0;
    while (who < 0 && cycles < 40) begin
      tick;
      cycles++;
      check("ack_excl", 32'(ack0 & ack1), 32'd0);
      if (ack0) who = 0;
      else if (ack1) who = 1;
    end
    if (who < 0) check("ack_timeout", 32'd1, 32'd0);
  endtask

  int who, cyc;
  int exp_who;

  initial begin
    reset_ = 1'b0;
    req0 = 1'b0; req1 = 1'b0; a0 = 24'h0; a1 = 24'h0;
    req_w = 1'b0; a_w = 24'h0;
    tick; tick;
    check("rst_s", 32'(s_), 32'd1);
    check("rst_mr", 32'(mr_), 32'd1);
    check("rst_acks", 32'({ack0, ack1}), 32'd0);
    check("rst_dato", 32'(dato), 32'h00);
    check("rst_addr", 32'(a23_a0), 32'h000000);
    reset_ = 1'b1;
    tick;

    // Single read from requester 0
    a0 = 24'hFF0002; req0 = 1'b1;
    tick;
    check("t1_s_k", 32'(s_), 32'd0);
    check("t1_mr_k", 32'(mr_), 32'd1);
    check("t1_addr", 32'(a23_a0), 32'hFF0002);
    tick;
    check("t1_mr_k1", 32'(mr_), 32'd0);
    tick; tick;
    check("t1_noack_k3", 32'(ack0), 32'd0);
    check("t1_mr_k3", 32'(mr_), 32'd0);
    tick;
    check("t1_ack0", 32'(ack0), 32'd1);
    check("t1_dato", 32'(dato), 32'h41);
    check("t1_s_rise", 32'({s_, mr_}), 32'd3);
    check("t1_ack1", 32'(ack1), 32'd0);
    req0 = 1'b0;
    tick;
    check("t1_ack0_fall", 32'(ack0), 32'd0);
    tick;

    // Address change and early req drop during READ
    a0 = 24'hFF0002; req0 = 1'b1;
    tick; tick;
    a0 = 24'hFF0013; req0 = 1'b0;
    tick; tick;
    check("t2_noack", 32'(ack0), 32'd0);
    tick;
    check("t2_ack0", 32'(ack0), 32'd1);
    check("t2_dato", 32'(dato), 32'h41);
    check("t2_addr", 32'(a23_a0), 32'hFF0002);
    tick;
    check("t2_pulse", 32'(ack0), 32'd0);
    tick;

    // Contention: requester 1 waits for requester 0's full handshake
    a0 = 24'hFF0002; req0 = 1'b1;
    tick; tick;
    a1 = 24'hFF0013; req1 = 1'b1;
    tick; tick;
    check("t3_ack1_wait", 32'(ack1), 32'd0);
    check("t3_addr_hold", 32'(a23_a0), 32'hFF0002);
    tick;
    check("t3_ack0", 32'(ack0), 32'd1);
    tick;
    check("t3_ack0_held", 32'(ack0), 32'd1);
    check("t3_ack1_held", 32'(ack1), 32'd0);
    check("t3_addr_ack", 32'(a23_a0), 32'hFF0002);
    req0 = 1'b0;
    tick;
    check("t3_ack0_fall", 32'(ack0), 32'd0);
    check("t3_s_idle", 32'(s_), 32'd1);
    tick;
    check("t3_grant1_s", 32'(s_), 32'd0);
    check("t3_grant1_addr", 32'(a23_a0), 32'hFF0013);
    wait_ack(who, cyc);
    check("t3_who", 32'(who), 32'd1);
    check("t3_dato", 32'(dato), 32'h5A);
    req1 = 1'b0;
    tick; tick;

    // Reset in the middle of a read
    a0 = 24'hFF0007; req0 = 1'b1;
    tick; tick;
    #2 reset_ = 1'b0;
    #1;
    check("t4_rst_smr", 32'({s_, mr_}), 32'd3);
    check("t4_rst_acks", 32'({ack0, ack1}), 32'd0);
    check("t4_rst_dato", 32'(dato), 32'h00);
    tick;
    reset_ = 1'b1;
    wait_ack(who, cyc);
    check("t4_who", 32'(who), 32'd0);
    check("t4_latency", 32'(cyc), 32'd5);
    check("t4_dato", 32'(dato), 32'h20);
    req0 = 1'b0;
    tick; tick;

    // Tie after reset, then sustained contention alternates
    reset_ = 1'b0;
    tick;
    reset_ = 1'b1;
    a0 = 24'hFF0000; a1 = 24'hFF0013;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_who = i % 2;
      if (i > 0) begin
        tick;
        check($sformatf("rr%0d_s", i), 32'(s_), 32'd0);
        check($sformatf("rr%0d_addr", i), 32'(a23_a0), exp_who == 0 ? 32'hFF0000 : 32'hFF0013);
      end
      wait_ack(who, cyc);
      check($sformatf("rr%0d_who", i), 32'(who), 32'(exp_who));
      check($sformatf("rr%0d_dato", i), 32'(dato), exp_who == 0 ? 32'(NOP_OPCODE) : 32'h5A);
      if (who == 0) req0 = 1'b0;
      else req1 = 1'b0;
      if (i == 4) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick;
      check($sformatf("rr%0d_ack_fall", i), 32'({ack0, ack1}), 32'd0);
      if (i < 4) begin
        if (who == 0) req0 = 1'b1;
        else req1 = 1'b1;
      end
    end
    tick;

    // WAIT_CYCLES = 0 instance
    a_w = 24'hFF0007; req_w = 1'b1;
    tick;
    check("w0_s_k", 32'(s_w), 32'd0);
    check("w0_mr_k", 32'(mr_w), 32'd1);
    tick;
    check("w0_mr_k1", 32'(mr_w), 32'd0);
    tick;
    check("w0_mr_k2", 32'(mr_w), 32'd1);
    check("w0_ack", 32'(ack_w), 32'd1);
    check("w0_dato", 32'(dato_w), 32'h20);
    check("w0_ack1", 32'(ack1_w), 32'd0);
    req_w = 1'b0;
    tick;
    check("w0_ack_fall", 32'(ack_w), 32'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
